mips_alu: RTL and testbench
===========================

Name: mips_alu

Overview:
- 32-bit MIPS-style ALU with registered outputs.
- Sits in the execute stage; opselect comes from ALU control decode.
- Computes one of 16 operations on x and y, plus overflow, carry and zero flags.
- All outputs are registered, giving one cycle of latency.

Parameters:
- WIDTH, 32, operand/result width (fixed at 32; shift amounts use 5 bits)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- opselect  input  4  operation select
- x  input  32  operand A
- y  input  32  operand B
- res  output  32  registered result
- v  output  1  registered signed-overflow flag
- c_out  output  1  registered carry-out flag
- zero  output  1  registered flag, 1 when res == 0

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: while rst_n = 0, res = 0, v = 0, c_out = 0, zero = 0, immediately and independent of clk. These hold until the first rising clk edge with rst_n = 1.
- Latency: inputs sampled on rising clk edge N; outputs valid after edge N and held until edge N+1. There is no handshake; a new op is accepted every cycle.
- Reset asserted mid-operation discards the pending result. The first post-reset edge registers the current inputs normally.
- Opcode map (res computation):
  - 0000 AND: x & y
  - 0001 OR: x | y
  - 0010 ADD: x + y (mod 2^32)
  - 0011 XOR: x ^ y
  - 0100 SLL: x << y[4:0]
  - 0101 SRL: x >> y[4:0], logical
  - 0110 SUB: x - y (mod 2^32)
  - 0111 SLT: 1 if signed(x) < signed(y), else 0. Must be correct even when x - y overflows.
  - 1000 SRA: signed(x) >>> y[4:0]
  - 1001 SLTU: 1 if unsigned(x) < unsigned(y), else 0
  - 1010 LUI: {y[15:0], 16'h0000}
  - 1011 XNOR: ~(x ^ y)
  - 1100 NOR: ~(x | y)
  - 1101 PASS_X: x
  - 1110 PASS_Y: y
  - 1111 reserved: res = 0
- Shifts ignore y[31:5]; a shift amount of 0 returns x unchanged.
- c_out:
  - ADD: carry out of bit 31 of x + y.
  - SUB: carry out of x + ~y + 1, i.e. 1 when unsigned x >= y (no borrow).
  - All other ops: 0.
- v:
  - ADD: 1 when x[31] == y[31] and res[31] != x[31].
  - SUB: 1 when x[31] != y[31] and res[31] != x[31].
  - All other ops: 0.
- zero: 1 when the 32-bit result being registered equals 0, for every opcode including reserved 1111 (so 1111 registers zero = 1).
- Flags and res update together on the same edge.
- Implementation: a single combinational op mux feeding one register bank. No internal state beyond the output registers.

Test Plan:
- Reset then clock with any inputs: during rst_n = 0, all outputs are 0. After release, the first edge registers the current op.
- ADD, x = 32'h7FFFFFFF, y = 1 -> res = 32'h80000000, v = 1, c_out = 0, zero = 0. Then x = y = 32'hFFFFFFFF -> res = 32'hFFFFFFFE, c_out = 1, v = 0.
- SUB, x = y = 32'h00000005 -> res = 0, zero = 1, c_out = 1, v = 0. Then x = 32'h80000000, y = 1 -> res = 32'h7FFFFFFF, v = 1, c_out = 1.
- SLT, x = 32'h80000000, y = 1 -> res = 1. SLTU on the same operands -> res = 0. SLT with x = 32'h7FFFFFFF, y = 32'hFFFFFFFF -> res = 0 (overflow case).
- Shifts with x = 32'h80000001, y = 32'h00000024 (shamt 4): SLL -> 32'h00000010, SRL -> 32'h08000000, SRA -> 32'hF8000000. LUI with y = 32'h0000ABCD -> 32'hABCD0000.
- Sweep all 16 opcodes with x = 32'hF0F0F0F0, y = 32'h0FF00FF0, one per cycle:
  - Check one-cycle latency and logical results: AND = 32'h00F000F0, OR = 32'hFFF0FFF0, XOR = 32'hFF00FF00, NOR = 32'h000F000F.
  - 1111 gives res = 0, zero = 1.
  - v and c_out are 0 for all non-arithmetic ops.

Source files
------------

// File: rtl/mips_alu.sv
// Execute-stage ALU: one combinational op mux feeding a single output register bank.
// No handshake: a new opselect/x/y is sampled on every rising edge; outputs follow one cycle later.
module mips_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       opselect,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] res,
  output logic             v,
  output logic             c_out,
  output logic             zero
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_LUI  = 4'b1010;
  localparam logic [3:0] OP_XNOR = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_PASX = 4'b1101;
  localparam logic [3:0] OP_PASY = 4'b1110;

  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] res_d;
  logic             v_d;
  logic             c_d;
  logic             zero_d;

  // Subtraction as x + ~y + 1 so the carry out is the MIPS "no borrow" flag.
  assign add_full = {1'b0, x} + {1'b0, y};
  assign sub_full = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, 1'b1};
  assign shamt    = y[4:0];

  always_comb begin
    res_d = '0;
    v_d   = 1'b0;
    c_d   = 1'b0;
    case (opselect)
      OP_AND:  res_d = x & y;
      OP_OR:   res_d = x | y;
      OP_ADD: begin
        res_d = add_full[WIDTH-1:0];
        c_d   = add_full[WIDTH];
        v_d   = (x[WIDTH-1] == y[WIDTH-1]) && (add_full[WIDTH-1] != x[WIDTH-1]);
      end
      OP_XOR:  res_d = x ^ y;
      OP_SLL:  res_d = x << shamt;
      OP_SRL:  res_d = x >> shamt;
      OP_SUB: begin
        res_d = sub_full[WIDTH-1:0];
        c_d   = sub_full[WIDTH];
        v_d   = (x[WIDTH-1] != y[WIDTH-1]) && (sub_full[WIDTH-1] != x[WIDTH-1]);
      end
      // Direct signed compare, so SLT stays correct when x - y overflows.
      OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      OP_SRA:  res_d = $signed(x) >>> shamt;
      OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, (x < y)};
      OP_LUI:  res_d = {y[15:0], {(WIDTH-16){1'b0}}};
      OP_XNOR: res_d = ~(x ^ y);
      OP_NOR:  res_d = ~(x | y);
      OP_PASX: res_d = x;
      OP_PASY: res_d = y;
      default: res_d = '0;
    endcase
    zero_d = (res_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res   <= '0;
      v     <= 1'b0;
      c_out <= 1'b0;
      zero  <= 1'b0;
    end else begin
      res   <= res_d;
      v     <= v_d;
      c_out <= c_d;
      zero  <= zero_d;
    end
  end

endmodule

// File: tb/tb_mips_alu.sv
// Bench for mips_alu: directed corner steps, an opcode sweep with latency checks,
// an asynchronous mid-run reset, and randomized ops against an arithmetic reference model.
module tb_mips_alu;

  logic        clk;
  logic        rst_n;
  logic [3:0]  opselect;
  logic [31:0] x;
  logic [31:0] y;
  logic [31:0] res;
  logic        v;
  logic        c_out;
  logic        zero;

  int checks = 0;
  int errors = 0;

  mips_alu #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opselect (opselect),
    .x        (x),
    .y        (y),
    .res      (res),
    .v        (v),
    .c_out    (c_out),
    .zero     (zero)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain 64-bit integer arithmetic; result packed as {res, v, c_out, zero}.
  function automatic logic [34:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned p2;
    longint          sa;
    longint          sb;
    longint          ps;
    longint          t;
    logic [31:0]     r;
    logic            ov;
    logic            cy;
    logic [4:0]      sh;
    ua = a;
    ub = b;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = b[4:0];
    p2 = 64'd1 << sh;
    ps = longint'(p2);
    r  = 32'd0;
    ov = 1'b0;
    cy = 1'b0;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2: begin
        r  = 32'(ua + ub);
        cy = (ua + ub) >= 64'h1_0000_0000;
        t  = sa + sb;
        ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      4'd3:  r = a ^ b;
      4'd4:  r = 32'(ua * p2);
      4'd5:  r = 32'(ua / p2);
      4'd6: begin
        r  = 32'(ua - ub);
        cy = ua >= ub;
        t  = sa - sb;
        ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd8: begin
        // Floor division by 2^sh, the arithmetic meaning of a signed right shift.
        if (sa >= 0) t = sa / ps;
        else         t = -((-sa + ps - 1) / ps);
        r = 32'(t);
      end
      4'd9:  r = (ua < ub) ? 32'd1 : 32'd0;
      4'd10: r = 32'((ub % 64'd65536) * 64'd65536);
      4'd11: r = ~(a ^ b);
      4'd12: r = ~(a | b);
      4'd13: r = a;
      4'd14: r = b;
      default: r = 32'd0;
    endcase
    return {r, ov, cy, (r == 32'd0)};
  endfunction

  // Scoreboard comparison on the packed {res, v, c_out, zero} view
  task automatic check(input string tag, input logic [34:0] exp);
    logic [34:0] obs;
    obs = {res, v, c_out, zero};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs res=%h v=%b c=%b z=%b exp res=%h v=%b c=%b z=%b",
             tag, obs[34:3], obs[2], obs[1], obs[0], exp[34:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Driver: present one op, let one edge register it, sample 1 time unit later
  task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    opselect = op;
    x        = a;
    y        = b;
    @(posedge clk);
    #1;
  endtask

  logic [34:0] prev_exp;
  logic [31:0] ra;
  logic [31:0] rb;
  logic [3:0]  rop;
  logic [31:0] corner [6];

  initial begin
    corner[0] = 32'h0000_0000;
    corner[1] = 32'hFFFF_FFFF;
    corner[2] = 32'h7FFF_FFFF;
    corner[3] = 32'h8000_0000;
    corner[4] = 32'h0000_0001;
    corner[5] = 32'h0000_001F;

    // Reset is asynchronous: outputs are 0 before any clock edge
    rst_n    = 1'b0;
    opselect = 4'd2;
    x        = 32'h7FFF_FFFF;
    y        = 32'h0000_0001;
    #2;
    check("reset_async", 35'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", 35'd0);

    // First post-reset edge registers the current inputs (ADD overflow)
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("add_ovf", {32'h8000_0000, 1'b1, 1'b0, 1'b0});

    apply(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("add_carry", {32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0});
    apply(4'd6, 32'h0000_0005, 32'h0000_0005);
    check("sub_zero", {32'h0, 1'b0, 1'b1, 1'b1});
    apply(4'd6, 32'h8000_0000, 32'h0000_0001);
    check("sub_ovf", {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0});
    apply(4'd6, 32'h0000_0001, 32'h0000_0002);
    check("sub_borrow", {32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0});
    apply(4'd7, 32'h8000_0000, 32'h0000_0001);
    check("slt_neg", {32'h1, 1'b0, 1'b0, 1'b0});
    apply(4'd9, 32'h8000_0000, 32'h0000_0001);
    check("sltu", {32'h0, 1'b0, 1'b0, 1'b1});
    apply(4'd7, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    check("slt_ovf", {32'h0, 1'b0, 1'b0, 1'b1});
    apply(4'd4, 32'h8000_0001, 32'h0000_0024);
    check("sll", {32'h0000_0010, 1'b0, 1'b0, 1'b0});
    apply(4'd5, 32'h8000_0001, 32'h0000_0024);
    check("srl", {32'h0800_0000, 1'b0, 1'b0, 1'b0});
    apply(4'd8, 32'h8000_0001, 32'h0000_0024);
    check("sra", {32'hF800_0000, 1'b0, 1'b0, 1'b0});
    apply(4'd8, 32'h8000_0001, 32'hFFFF_FFE0);
    check("sra_sh0", {32'h8000_0001, 1'b0, 1'b0, 1'b0});
    apply(4'd10, 32'h1234_5678, 32'h0000_ABCD);
    check("lui", {32'hABCD_0000, 1'b0, 1'b0, 1'b0});

    // Opcode sweep: outputs hold the previous op until the next edge
    prev_exp = {32'hABCD_0000, 1'b0, 1'b0, 1'b0};
    for (int op = 0; op < 16; op++) begin
      opselect = 4'(op);
      x        = 32'hF0F0_F0F0;
      y        = 32'h0FF0_0FF0;
      #2;
      check($sformatf("sweep_hold_%0d", op), prev_exp);
      @(posedge clk);
      #1;
      prev_exp = model(4'(op), 32'hF0F0_F0F0, 32'h0FF0_0FF0);
      check($sformatf("sweep_op_%0d", op), prev_exp);
      case (op)
        0:  check("sweep_and", {32'h00F0_00F0, 3'b000});
        1:  check("sweep_or",  {32'hFFF0_FFF0, 3'b000});
        3:  check("sweep_xor", {32'hFF00_FF00, 3'b000});
        12: check("sweep_nor", {32'h000F_000F, 3'b000});
        15: check("sweep_rsvd", {32'h0, 3'b001});
        default: ;
      endcase
    end

    // Asynchronous reset mid-cycle discards the registered result
    apply(4'd13, 32'hDEAD_BEEF, 32'h0);
    check("pass_x", {32'hDEAD_BEEF, 3'b000});
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid", 35'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(4'd14, 32'h0, 32'hCAFE_0001);
    check("post_reset_first", {32'hCAFE_0001, 3'b000});

    // Randomized ops, operands mixing corners and uniform values
    for (int i = 0; i < 400; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      apply(rop, ra, rb);
      check($sformatf("rand_op%0d", rop), model(rop, ra, rb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
